// File: rtl/db_stream_reader_if.sv
// Bundles the memory read port and the downstream stream port of db_stream_reader.
// master is the reader's view; slave is the memory/consumer side.
interface db_stream_reader_if #(
   parameter int DATA_WIDTH = 16
);
   logic                  ren_out;
   logic [DATA_WIDTH-1:0] mem_data_in;
   logic                  mem_valid_in;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;

   modport master (
      output ren_out,
      output out_data,
      output out_valid,
      input  mem_data_in,
      input  mem_valid_in,
      input  out_ready
   );

   modport slave (
      input  ren_out,
      input  out_data,
      input  out_valid,
      output mem_data_in,
      output mem_valid_in,
      output out_ready
   );
endinterface

// File: rtl/db_stream_reader.sv
// Issues a frame of memory reads and buffers the returned words in a small FIFO,
// only requesting a read when a FIFO slot is guaranteed for its data.
module db_stream_reader #(
   parameter int DATA_WIDTH = 16,
   parameter int FIFO_DEPTH = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clk_en,
   input  logic              flush,
   input  logic              start,
   input  logic [15:0]       depth,
   db_stream_reader_if.master bus,
   output logic              busy,
   output logic              frame_done,
   output logic [15:0]       rd_count,
   output logic              err
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

   state_t                state_q, state_d;
   logic [15:0]           depth_q, depth_d;
   logic [15:0]           rd_count_q, rd_count_d;
   logic [CW-1:0]         outstanding_q, outstanding_d;
   logic [CW-1:0]         fifo_count_q, fifo_count_d;
   logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
   logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] mem_d [FIFO_DEPTH];
   logic                  err_q, err_d;
   logic                  frame_done_q, frame_done_d;

   logic                  ren;
   logic                  out_valid;
   logic                  pop;
   logic                  accept;
   logic                  push;
   logic                  fifo_full;
   logic [CW:0]           credit_sum;

   // Credit: buffered words plus reads in flight must leave room for one more word.
   assign credit_sum = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
   assign fifo_full  = (fifo_count_q == FULL_COUNT);
   assign ren        = clk_en && (state_q == ISSUE) && (rd_count_q < depth_q)
                       && (credit_sum < {1'b0, FULL_COUNT});
   assign out_valid  = clk_en && (fifo_count_q != '0);
   assign pop        = out_valid && bus.out_ready;
   assign accept     = clk_en && bus.mem_valid_in && (outstanding_q != '0);
   assign push       = accept && !fifo_full;

   assign bus.ren_out   = ren;
   assign bus.out_valid = out_valid;
   assign bus.out_data  = mem_q[rd_ptr_q];
   assign busy          = (state_q != IDLE);
   assign frame_done    = frame_done_q;
   assign rd_count      = rd_count_q;
   assign err           = err_q;

   always_comb begin
      state_d       = state_q;
      depth_d       = depth_q;
      rd_count_d    = rd_count_q;
      outstanding_d = outstanding_q;
      fifo_count_d  = fifo_count_q;
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      mem_d         = mem_q;
      err_d         = err_q;
      frame_done_d  = frame_done_q;

      if (clk_en) begin
         frame_done_d = 1'b0;
         if (flush) begin
            state_d       = IDLE;
            depth_d       = '0;
            rd_count_d    = '0;
            outstanding_d = '0;
            fifo_count_d  = '0;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            mem_d         = '{default: '0};
            err_d         = 1'b0;
         end else begin
            if (ren) begin
               rd_count_d = rd_count_q + 16'd1;
            end
            if (ren && !accept) begin
               outstanding_d = outstanding_q + CW'(1);
            end else if (!ren && accept) begin
               outstanding_d = outstanding_q - CW'(1);
            end

            // Unsolicited returns and (unreachable) overflow are dropped and flagged.
            if (bus.mem_valid_in && ((outstanding_q == '0) || fifo_full)) begin
               err_d = 1'b1;
            end
            if (push) begin
               mem_d[wr_ptr_q] = bus.mem_data_in;
               wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
               rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (push && !pop) begin
               fifo_count_d = fifo_count_q + CW'(1);
            end else if (pop && !push) begin
               fifo_count_d = fifo_count_q - CW'(1);
            end

            case (state_q)
               IDLE: begin
                  if (start) begin
                     if (depth != '0) begin
                        depth_d    = depth;
                        rd_count_d = '0;
                        state_d    = ISSUE;
                     end else begin
                        frame_done_d = 1'b1;
                     end
                  end
               end
               ISSUE: begin
                  if (ren && ((rd_count_q + 16'd1) == depth_q)) begin
                     state_d = DRAIN;
                  end
               end
               DRAIN: begin
                  if ((outstanding_q == '0) && (fifo_count_q == '0)) begin
                     state_d      = IDLE;
                     frame_done_d = 1'b1;
                  end
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= IDLE;
         depth_q       <= '0;
         rd_count_q    <= '0;
         outstanding_q <= '0;
         fifo_count_q  <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         mem_q         <= '{default: '0};
         err_q         <= 1'b0;
         frame_done_q  <= 1'b0;
      end else begin
         state_q       <= state_d;
         depth_q       <= depth_d;
         rd_count_q    <= rd_count_d;
         outstanding_q <= outstanding_d;
         fifo_count_q  <= fifo_count_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         mem_q         <= mem_d;
         err_q         <= err_d;
         frame_done_q  <= frame_done_d;
      end
   end
endmodule
